// File: rtl/modulator_axi_pkg.sv
// Shared definitions for the modulator AXI4-Lite register file: register
// indices, response codes, write-channel FSM states and the byte-lane merge.
package modulator_axi_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DUTY    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int NUM_REGS = int'(REG_SCRATCH) + 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_BOTH,
    WR_RESP
  } wr_state_t;

  // Lanes whose strobe bit is clear keep their current byte.
  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = data[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/modulator_axi_shadow.sv
// Period/duty shadow latch: the modulator only sees new PERIOD/DUTY values
// at a PWM period boundary, so an update never lands mid-period.
module modulator_axi_shadow
  import modulator_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        period_end,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  output logic [31:0] shadow_period,
  output logic [31:0] shadow_duty
);

  logic [31:0] shadow_period_reg;
  logic [31:0] shadow_duty_reg;

  // A boundary coinciding with a commit picks up the value before the write,
  // since the register file updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period_reg <= '0;
      shadow_duty_reg   <= '0;
    end else if (period_end) begin
      shadow_period_reg <= period;
      shadow_duty_reg   <= duty;
    end
  end

  assign shadow_period = shadow_period_reg;
  assign shadow_duty   = shadow_duty_reg;

endmodule

// File: rtl/modulator_axi_regs.sv
// AXI4-Lite slave with four 32-bit R/W registers feeding the PWM modulator.
// Define MODULATOR_REGS_SHADOW_EN to route period/duty through a shadow latch.
module modulator_axi_regs
  import modulator_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              period_end,
  output logic [31:0]                       mod_ctrl,
  output logic [31:0]                       mod_period,
  output logic [31:0]                       mod_duty,
  output logic [3:0]                        reg_wr_pulse
);

  wr_state_t   wr_state_reg;
  wr_state_t   wr_state_next;
  logic [1:0]  wr_idx_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;

  logic [31:0] reg_value [NUM_REGS];
  logic [3:0]  wr_pulse_reg;
  logic [3:0]  wr_pulse_next;

  logic        rvalid_reg;
  logic [31:0] rdata_reg;

  // Readiness is a pure function of the write state, so AW and W can be taken
  // in either order and each drops READY once it is held.
  assign S_AXI_AWREADY = (wr_state_reg == WR_IDLE) || (wr_state_reg == WR_HAVE_W);
  assign S_AXI_WREADY  = (wr_state_reg == WR_IDLE) || (wr_state_reg == WR_HAVE_AW);
  assign S_AXI_BVALID  = (wr_state_reg == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign commit = (wr_state_reg == WR_BOTH);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_reg <= WR_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_next = WR_BOTH;
        end else if (aw_hs) begin
          wr_state_next = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_state_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          wr_state_next = WR_BOTH;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          wr_state_next = WR_BOTH;
        end
      end
      WR_BOTH: begin
        wr_state_next = WR_RESP;
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_next = WR_IDLE;
        end
      end
      default: begin
        wr_state_next = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_idx_reg <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
    end else begin
      if (aw_hs) begin
        wr_idx_reg <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        wdata_reg <= S_AXI_WDATA;
        wstrb_reg <= S_AXI_WSTRB;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] value_reg;
      logic        hit;

      assign hit = commit && (wr_idx_reg == 2'(gi));

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          value_reg <= '0;
        end else if (hit) begin
          value_reg <= strb_merge(value_reg, wdata_reg, wstrb_reg);
        end
      end

      assign reg_value[gi]     = value_reg;
      assign wr_pulse_next[gi] = hit;
    end
  endgenerate

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= wr_pulse_next;
    end
  end

  assign reg_wr_pulse = wr_pulse_reg;

  // Read side is independent of the write FSM; a read in the commit cycle
  // samples the register before the write lands.
  assign S_AXI_ARREADY = !rvalid_reg;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= reg_value[S_AXI_ARADDR[3:2]];
    end else if (S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign S_AXI_RRESP  = RESP_OKAY;

  assign mod_ctrl = reg_value[REG_CTRL];

`ifdef MODULATOR_REGS_SHADOW_EN
  modulator_axi_shadow u_shadow (
    .clk           (S_AXI_ACLK),
    .rst_n         (S_AXI_ARESETN),
    .period_end    (period_end),
    .period        (reg_value[REG_PERIOD]),
    .duty          (reg_value[REG_DUTY]),
    .shadow_period (mod_period),
    .shadow_duty   (mod_duty)
  );
`else
  logic unused_period_end;
  assign unused_period_end = period_end;
  assign mod_period        = reg_value[REG_PERIOD];
  assign mod_duty          = reg_value[REG_DUTY];
`endif

  // Protection bits and non-decoded address bits are intentionally ignored.
  logic unused_axi;
  assign unused_axi = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule
